// File: rtl/rng_pkg.sv
// Shared types and constants for the multi-channel RNG stream merger.
//   RNG_WORD_W     : width of one entropy-unit word
//   RNG_MAX_OUT_W  : widest supported AXIS beat (sizes the FIFO entry struct)
//   rng_state_t    : run-control FSM state
//   rng_entry_t    : FIFO entry {last, data}; data is zero-extended to RNG_MAX_OUT_W
//   rng_beat_bytes : bytes carried by one beat of a given AXIS width
package rng_pkg;

    localparam int unsigned RNG_WORD_W    = 32;
    localparam int unsigned RNG_MAX_OUT_W = 128;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } rng_state_t;

    typedef struct packed {
        logic                     last;
        logic [RNG_MAX_OUT_W-1:0] data;
    } rng_entry_t;

    function automatic int unsigned rng_beat_bytes(input int unsigned out_w);
        return out_w / 8;
    endfunction

endpackage

// File: rtl/fifo.sv
// Synchronous first-word-fall-through FIFO with a registered output stage.
// Capacity SIZE entries in total (memory plus output register).
//   clk, rst     : clock, asynchronous active-high reset
//   soft_rst     : synchronous flush of all entries
//   wr_en, din   : write port (ignored while full)
//   full         : registered full flag
//   rd_en        : pop request, honoured when valid
//   dout, valid  : registered head entry and its valid flag
module fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SIZE  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             soft_rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             valid
);

    localparam int unsigned AW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int unsigned CW = $clog2(SIZE + 1);

    logic [WIDTH-1:0] mem [SIZE];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    used_q;

    logic          wr_ok_c;
    logic          pop_c;
    logic          load_c;
    logic          mem_rd_c;
    logic          bypass_c;
    logic          mem_wr_c;
    logic [CW-1:0] mem_cnt_c;
    logic [CW-1:0] used_d;

    // Output register refills from memory first, else straight from din when memory is empty.
    always_comb begin : ctrl
        wr_ok_c   = wr_en && !full;
        pop_c     = valid && rd_en;
        load_c    = !valid || pop_c;
        mem_cnt_c = used_q - CW'(valid);
        mem_rd_c  = load_c && (mem_cnt_c != '0);
        bypass_c  = load_c && (mem_cnt_c == '0) && wr_ok_c;
        mem_wr_c  = wr_ok_c && !bypass_c;
        used_d    = used_q + CW'(wr_ok_c) - CW'(pop_c);
    end

    // Storage array, no reset
    always_ff @(posedge clk) begin
        if (mem_wr_c && !soft_rst) begin
            mem[wr_ptr_q] <= din;
        end
    end

    // Pointers, occupancy and output stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
            full     <= 1'b0;
            dout     <= '0;
            valid    <= 1'b0;
        end else if (soft_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
            full     <= 1'b0;
            dout     <= '0;
            valid    <= 1'b0;
        end else begin
            if (mem_wr_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (mem_rd_c) rd_ptr_q <= rd_ptr_q + AW'(1);
            used_q <= used_d;
            full   <= (used_d == CW'(SIZE));
            if (load_c) begin
                if (mem_rd_c) begin
                    dout  <= mem[rd_ptr_q];
                    valid <= 1'b1;
                end else if (bypass_c) begin
                    dout  <= din;
                    valid <= 1'b1;
                end else begin
                    valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/rng_stream_mux.sv
// Merges raw words from NUM_CH entropy units round-robin, packs them into
// OUT_W-bit beats, buffers them and streams them over AXI Stream.
//   clk, rst               : clock, asynchronous active-high reset
//   ch_data/ch_valid       : per-channel 32-bit words and one-cycle strobes
//   ch_mask                : enabled channels, latched at go
//   go/stop                : run start and abort pulses
//   send_bytes/dma_bytes   : run length and chunk length (0 = no chunk TLAST)
//   run, over              : run active, sticky FIFO-full-while-beat-ready
//   sent_bytes, drop_cnt   : bytes written this run, saturating dropped words
//   axis_*                 : AXI Stream master
module rng_stream_mux
    import rng_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned OUT_W      = 64,
    parameter int unsigned FIFO_DEPTH = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [RNG_WORD_W*NUM_CH-1:0] ch_data,
    input  logic [NUM_CH-1:0]            ch_valid,
    input  logic [NUM_CH-1:0]            ch_mask,
    input  logic                         go,
    input  logic                         stop,
    input  logic [31:0]                  send_bytes,
    input  logic [31:0]                  dma_bytes,
    output logic                         run,
    output logic                         over,
    output logic [31:0]                  sent_bytes,
    output logic [31:0]                  drop_cnt,
    output logic [OUT_W-1:0]             axis_tdata,
    output logic                         axis_tlast,
    output logic                         axis_tvalid,
    input  logic                         axis_tready
);

    localparam int unsigned BEAT_B = rng_beat_bytes(OUT_W);
    localparam int unsigned K      = OUT_W / RNG_WORD_W;
    localparam int unsigned IDX_W  = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned DINC_W = $clog2(NUM_CH + 1);

    rng_state_t state_q, state_d;

    logic [NUM_CH-1:0]     mask_q;
    logic [NUM_CH-1:0]     hold_full_q;
    logic [RNG_WORD_W-1:0] hold_data_q [NUM_CH];
    logic [CH_W-1:0]       ptr_q;
    logic [RNG_WORD_W-1:0] pack_q [K];
    logic [IDX_W-1:0]      idx_q;
    logic [31:0]           chunk_q;

    logic [31:0]           send_rnd_c;
    logic [31:0]           dma_rnd_c;
    logic                  run_act_c;
    logic                  start_c;
    logic                  grant_any_c;
    logic [CH_W-1:0]       grant_ch_c;
    logic [CH_W-1:0]       cand_c;
    logic                  complete_c;
    logic                  blocked_c;
    logic                  grant_c;
    logic                  wr_c;
    logic [NUM_CH-1:0]     granted_c;
    logic [RNG_WORD_W-1:0] grant_word_c;
    logic [OUT_W-1:0]      beat_c;
    logic [31:0]           sent_next_c;
    logic [31:0]           chunk_next_c;
    logic                  end_c;
    logic                  chunk_last_c;
    rng_entry_t            entry_c;
    logic [NUM_CH-1:0]     load_c;
    logic [DINC_W-1:0]     drop_inc_c;
    logic [32:0]           drop_sum_c;
    logic [31:0]           drop_next_c;
    logic                  fifo_full;
    logic [OUT_W:0]        fifo_dout;

    assign run         = (state_q == ST_RUN);
    assign axis_tlast  = fifo_dout[OUT_W];
    assign axis_tdata  = fifo_dout[OUT_W-1:0];

    // Byte counts are used in whole beats
    assign send_rnd_c = send_bytes & ~32'(BEAT_B - 1);
    assign dma_rnd_c  = dma_bytes  & ~32'(BEAT_B - 1);

    // Round-robin pick: first full masked holding register at or after ptr_q
    always_comb begin : arbiter
        grant_any_c = 1'b0;
        grant_ch_c  = '0;
        cand_c      = '0;
        for (int unsigned j = 0; j < NUM_CH; j++) begin
            cand_c = CH_W'((32'(ptr_q) + j) % NUM_CH);
            if (!grant_any_c && hold_full_q[cand_c] && mask_q[cand_c]) begin
                grant_any_c = 1'b1;
                grant_ch_c  = cand_c;
            end
        end
    end

    // Grant qualification: a completing word is withheld while the FIFO is full
    always_comb begin : grant_ctrl
        run_act_c    = (state_q == ST_RUN) && !stop;
        complete_c   = (idx_q == IDX_W'(K - 1));
        blocked_c    = complete_c && fifo_full;
        grant_c      = run_act_c && grant_any_c && !blocked_c;
        wr_c         = grant_c && complete_c;
        granted_c    = '0;
        if (grant_c) granted_c[grant_ch_c] = 1'b1;
        grant_word_c = hold_data_q[grant_ch_c];
    end

    // Beat image with the granted word dropped into the current slot
    always_comb begin : pack_beat
        beat_c = '0;
        for (int unsigned k = 0; k < K; k++) begin
            if (IDX_W'(k) == idx_q) beat_c[k*RNG_WORD_W +: RNG_WORD_W] = grant_word_c;
            else                    beat_c[k*RNG_WORD_W +: RNG_WORD_W] = pack_q[k];
        end
    end

    // Per-beat byte accounting and TLAST decision
    always_comb begin : accounting
        sent_next_c  = sent_bytes + 32'(BEAT_B);
        chunk_next_c = chunk_q + 32'(BEAT_B);
        end_c        = (sent_next_c == send_rnd_c);
        chunk_last_c = (dma_rnd_c != '0) && (chunk_next_c == dma_rnd_c);
        entry_c.last = end_c || chunk_last_c;
        entry_c.data = RNG_MAX_OUT_W'(beat_c);
    end

    generate
        if (OUT_W < RNG_MAX_OUT_W) begin : g_entry_pad
            logic unused_pad;
            assign unused_pad = ^entry_c.data[RNG_MAX_OUT_W-1:OUT_W];
        end
    endgenerate

    // Holding-register loads and saturating drop count
    always_comb begin : hold_ctrl
        load_c     = '0;
        drop_inc_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (run_act_c && mask_q[i] && ch_valid[i]) begin
                if (!hold_full_q[i] || granted_c[i]) load_c[i] = 1'b1;
                else                                 drop_inc_c = drop_inc_c + DINC_W'(1);
            end
        end
        drop_sum_c  = {1'b0, drop_cnt} + 33'(drop_inc_c);
        drop_next_c = drop_sum_c[32] ? '1 : drop_sum_c[31:0];
    end

    // FSM next state; stop dominates go
    always_comb begin : fsm_next
        state_d = state_q;
        start_c = 1'b0;
        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (go && (send_rnd_c != '0) && (ch_mask != '0)) begin
                        state_d = ST_RUN;
                        start_c = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (wr_c && end_c) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q      <= '0;
            hold_full_q <= '0;
            ptr_q       <= '0;
            idx_q       <= '0;
            chunk_q     <= '0;
            sent_bytes  <= '0;
            drop_cnt    <= '0;
            over        <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) hold_data_q[i] <= '0;
            for (int unsigned k = 0; k < K; k++)      pack_q[k]      <= '0;
        end else if (start_c) begin
            mask_q      <= ch_mask;
            hold_full_q <= '0;
            ptr_q       <= '0;
            idx_q       <= '0;
            chunk_q     <= '0;
            sent_bytes  <= '0;
            drop_cnt    <= '0;
            over        <= 1'b0;
        end else if (!run_act_c) begin
            // Idle or aborting: flush partial beat and holding registers
            hold_full_q <= '0;
            ptr_q       <= '0;
            idx_q       <= '0;
        end else begin
            drop_cnt <= drop_next_c;
            if (blocked_c && grant_any_c) over <= 1'b1;
            if (grant_c) begin
                ptr_q <= (32'(grant_ch_c) == NUM_CH - 1) ? '0 : grant_ch_c + CH_W'(1);
                if (complete_c) begin
                    idx_q      <= '0;
                    sent_bytes <= sent_next_c;
                    chunk_q    <= chunk_last_c ? '0 : chunk_next_c;
                end else begin
                    pack_q[idx_q] <= grant_word_c;
                    idx_q         <= idx_q + IDX_W'(1);
                end
            end
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (load_c[i]) hold_data_q[i] <= ch_data[i*RNG_WORD_W +: RNG_WORD_W];
            end
            hold_full_q <= (hold_full_q & ~granted_c) | load_c;
        end
    end

    fifo #(
        .WIDTH (OUT_W + 1),
        .SIZE  (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .soft_rst (stop),
        .wr_en    (wr_c),
        .din      ({entry_c.last, entry_c.data[OUT_W-1:0]}),
        .full     (fifo_full),
        .rd_en    (axis_tready),
        .dout     (fifo_dout),
        .valid    (axis_tvalid)
    );

endmodule

// File: tb/tb_rng_stream_mux.sv
// Scoreboard bench for rng_stream_mux: stimulus pushes expected {last, data}
// beats into a queue, a negedge monitor pops and compares every AXIS transfer.
module tb_rng_stream_mux;

    localparam int unsigned NUM_CH     = 4;
    localparam int unsigned OUT_W      = 64;
    localparam int unsigned FIFO_DEPTH = 4;

    logic                 clk;
    logic                 rst;
    logic [32*NUM_CH-1:0] ch_data;
    logic [NUM_CH-1:0]    ch_valid;
    logic [NUM_CH-1:0]    ch_mask;
    logic                 go;
    logic                 stop;
    logic [31:0]          send_bytes;
    logic [31:0]          dma_bytes;
    logic                 run;
    logic                 over;
    logic [31:0]          sent_bytes;
    logic [31:0]          drop_cnt;
    logic [OUT_W-1:0]     axis_tdata;
    logic                 axis_tlast;
    logic                 axis_tvalid;
    logic                 axis_tready;

    rng_stream_mux #(
        .NUM_CH     (NUM_CH),
        .OUT_W      (OUT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ch_data     (ch_data),
        .ch_valid    (ch_valid),
        .ch_mask     (ch_mask),
        .go          (go),
        .stop        (stop),
        .send_bytes  (send_bytes),
        .dma_bytes   (dma_bytes),
        .run         (run),
        .over        (over),
        .sent_bytes  (sent_bytes),
        .drop_cnt    (drop_cnt),
        .axis_tdata  (axis_tdata),
        .axis_tlast  (axis_tlast),
        .axis_tvalid (axis_tvalid),
        .axis_tready (axis_tready)
    );

    int               n_vec = 0;
    int               n_err = 0;
    int               n_beat = 0;
    logic [OUT_W:0]   sb_q [$];
    logic [OUT_W:0]   exp_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, run=%0b pending=%0d", run, sb_q.size());
        $fatal(1);
    end

    function automatic logic [31:0] word(input logic [7:0] tag, input int ch);
        return {tag, 16'hC0DE, 8'(ch)};
    endfunction

    task automatic set_tag(input logic [7:0] tag);
        for (int i = 0; i < int'(NUM_CH); i++) ch_data[i*32 +: 32] = word(tag, i);
    endtask

    task automatic push(input logic [7:0] tag, input int hi, input int lo, input logic last);
        sb_q.push_back({last, word(tag, hi), word(tag, lo)});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic start_run(input logic [3:0] mask, input logic [31:0] sb, input logic [31:0] db);
        ch_mask    = mask;
        send_bytes = sb;
        dma_bytes  = db;
        ch_valid   = '1;
        go         = 1'b1;
        step(1);
        go         = 1'b0;
        check("run_after_go", 64'(run), 64'd1);
    endtask

    task automatic wait_done(input string name, input int limit);
        int n;
        n = 0;
        while ((run || sb_q.size() != 0) && n < limit) begin
            step(1);
            n++;
        end
        n_vec++;
        if (run || sb_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_done: run=%0b pending=%0d, required run=0 pending=0", name, run, sb_q.size());
        end
        ch_valid = '0;
    endtask

    // Monitor: every AXIS transfer is checked against the scoreboard head
    always @(negedge clk) begin
        if (!rst && axis_tvalid && axis_tready) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL axis_beat%0d: got tlast=%0b tdata=%h, required no beat", n_beat, axis_tlast, axis_tdata);
            end else begin
                exp_e = sb_q.pop_front();
                if ({axis_tlast, axis_tdata} !== exp_e) begin
                    n_err++;
                    $display("FAIL axis_beat%0d: got tlast=%0b tdata=%h, required tlast=%0b tdata=%h",
                             n_beat, axis_tlast, axis_tdata, exp_e[OUT_W], exp_e[OUT_W-1:0]);
                end
            end
            n_beat++;
        end
    end

    initial begin
        rst         = 1'b1;
        ch_data     = '0;
        ch_valid    = '0;
        ch_mask     = '0;
        go          = 1'b0;
        stop        = 1'b0;
        send_bytes  = '0;
        dma_bytes   = '0;
        axis_tready = 1'b0;
        step(3);

        check("rst_tvalid", 64'(axis_tvalid), 64'd0);
        check("rst_tlast",  64'(axis_tlast),  64'd0);
        check("rst_tdata",  axis_tdata,       64'd0);
        check("rst_run",    64'(run),         64'd0);
        check("rst_over",   64'(over),        64'd0);
        check("rst_sent",   64'(sent_bytes),  64'd0);
        check("rst_drop",   64'(drop_cnt),    64'd0);
        rst = 1'b0;
        step(2);

        // Basic run: 4 beats, chunk TLAST on beats 2 and 4
        axis_tready = 1'b1;
        set_tag(8'h11);
        push(8'h11, 1, 0, 1'b0);
        push(8'h11, 3, 2, 1'b1);
        push(8'h11, 1, 0, 1'b0);
        push(8'h11, 3, 2, 1'b1);
        start_run(4'b1111, 32'd32, 32'd16);
        wait_done("basic", 100);
        check("basic_sent", 64'(sent_bytes), 64'd32);
        check("basic_drop", 64'(drop_cnt),   64'd24);
        check("basic_over", 64'(over),       64'd0);
        step(2);

        // Masking: only channels 0 and 2, masked strobes never count
        set_tag(8'h22);
        push(8'h22, 2, 0, 1'b0);
        push(8'h22, 2, 0, 1'b1);
        start_run(4'b0101, 32'd16, 32'd0);
        wait_done("mask", 100);
        check("mask_sent", 64'(sent_bytes), 64'd16);
        check("mask_drop", 64'(drop_cnt),   64'd4);
        step(2);

        // Odd length: 13 bytes rounds down to one 8-byte beat
        set_tag(8'h33);
        push(8'h33, 1, 0, 1'b1);
        start_run(4'b1111, 32'd13, 32'd0);
        wait_done("odd", 100);
        check("odd_sent", 64'(sent_bytes), 64'd8);
        check("odd_drop", 64'(drop_cnt),   64'd6);
        step(2);

        // Zero-length go is ignored
        ch_mask    = 4'b1111;
        send_bytes = 32'd7;
        go         = 1'b1;
        step(1);
        go         = 1'b0;
        check("zero_len_go_run", 64'(run), 64'd0);
        step(2);

        // Backpressure: FIFO fills after 4 beats, then 4 drops per cycle
        axis_tready = 1'b0;
        set_tag(8'h44);
        for (int b = 0; b < 16; b++) begin
            if (b % 2 == 0) push(8'h44, 1, 0, 1'b0);
            else            push(8'h44, 3, 2, b == 15);
        end
        start_run(4'b1111, 32'd128, 32'd0);
        step(12);
        check("bp_over",   64'(over),        64'd1);
        check("bp_tvalid", 64'(axis_tvalid), 64'd1);
        check("bp_sent",   64'(sent_bytes),  64'd32);
        begin
            logic [31:0] d0;
            d0 = drop_cnt;
            step(5);
            check("bp_drop_rate", 64'(drop_cnt - d0), 64'd20);
        end
        axis_tready = 1'b1;
        wait_done("bp", 400);
        check("bp_sent_final", 64'(sent_bytes), 64'd128);
        check("bp_over_hold",  64'(over),       64'd1);
        step(2);

        // Abort with 3 beats buffered; go colliding with stop is ignored
        axis_tready = 1'b0;
        set_tag(8'h55);
        start_run(4'b1111, 32'd128, 32'd0);
        step(7);
        check("abort_tvalid_pre", 64'(axis_tvalid), 64'd1);
        stop = 1'b1;
        go   = 1'b1;
        step(1);
        check("abort_tvalid", 64'(axis_tvalid), 64'd0);
        check("abort_run",    64'(run),         64'd0);
        check("abort_sent",   64'(sent_bytes),  64'd24);
        step(1);
        stop = 1'b0;
        go   = 1'b0;
        check("abort_idle_collision_run", 64'(run), 64'd0);
        ch_valid    = '0;
        axis_tready = 1'b1;
        step(6);
        check("abort_flushed", 64'(axis_tvalid), 64'd0);

        // Asynchronous reset mid-run
        axis_tready = 1'b0;
        set_tag(8'h66);
        start_run(4'b1111, 32'd128, 32'd0);
        step(12);
        check("rstmid_over_pre", 64'(over), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_tvalid", 64'(axis_tvalid), 64'd0);
        check("rstmid_tlast",  64'(axis_tlast),  64'd0);
        check("rstmid_tdata",  axis_tdata,       64'd0);
        check("rstmid_run",    64'(run),         64'd0);
        check("rstmid_over",   64'(over),        64'd0);
        check("rstmid_sent",   64'(sent_bytes),  64'd0);
        check("rstmid_drop",   64'(drop_cnt),    64'd0);
        ch_valid = '0;
        step(2);
        rst = 1'b0;
        step(2);

        // Restart after reset
        axis_tready = 1'b1;
        set_tag(8'h77);
        push(8'h77, 1, 0, 1'b0);
        push(8'h77, 3, 2, 1'b1);
        push(8'h77, 1, 0, 1'b0);
        push(8'h77, 3, 2, 1'b1);
        start_run(4'b1111, 32'd32, 32'd16);
        wait_done("restart", 100);
        check("restart_sent", 64'(sent_bytes), 64'd32);
        check("restart_drop", 64'(drop_cnt),   64'd24);
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
